// File: rtl/spi_flash_arbiter.sv
// Arbitrates the SPI flash pads between spimemio (XIP) and the SPI host.
// Optional starvation timeout pulse enabled by SPI_FLASH_ARB_TIMEOUT_EN.
module spi_flash_arbiter #(
  parameter int IDLE_CYCLES = 4,
  parameter int TIMEOUT     = 1024,
  parameter int NUM_CS      = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              memio_req_i,
  output logic              memio_gnt_o,
  input  logic              host_req_i,
  output logic              host_gnt_o,
  input  logic [NUM_CS-1:0] memio_csb_i,
  input  logic [NUM_CS-1:0] host_csb_i,
  output logic              use_spimemio_o,
  output logic              busy_o,
  output logic              timeout_intr_o
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_MEMIO,
    GNT_HOST,
    DRAIN
  } state_t;

  localparam logic [8:0] IDLE_LIM = 9'(IDLE_CYCLES);

  state_t            state;
  logic              last_memio;
  logic [7:0]        idle_cnt;
  logic [NUM_CS-1:0] old_csb;
  logic              csb_idle;
  logic              drain_done;

  // Only the previous owner's chip selects matter while draining.
  assign old_csb    = last_memio ? memio_csb_i : host_csb_i;
  assign csb_idle   = &old_csb;
  assign drain_done = (state == DRAIN) && csb_idle &&
                      (({1'b0, idle_cnt} + 9'd1) >= IDLE_LIM);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      memio_gnt_o    <= 1'b0;
      host_gnt_o     <= 1'b0;
      use_spimemio_o <= 1'b0;
      busy_o         <= 1'b0;
      last_memio     <= 1'b0;
      idle_cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memio_req_i && (!host_req_i || !last_memio)) begin
            state          <= GNT_MEMIO;
            memio_gnt_o    <= 1'b1;
            use_spimemio_o <= 1'b1;
            busy_o         <= 1'b1;
          end else if (host_req_i) begin
            state          <= GNT_HOST;
            host_gnt_o     <= 1'b1;
            use_spimemio_o <= 1'b0;
            busy_o         <= 1'b1;
          end
        end
        GNT_MEMIO: begin
          if (!memio_req_i) begin
            state       <= DRAIN;
            memio_gnt_o <= 1'b0;
            last_memio  <= 1'b1;
            idle_cnt    <= '0;
          end
        end
        GNT_HOST: begin
          if (!host_req_i) begin
            state      <= DRAIN;
            host_gnt_o <= 1'b0;
            last_memio <= 1'b0;
            idle_cnt   <= '0;
          end
        end
        DRAIN: begin
          if (!csb_idle) begin
            idle_cnt <= '0;
          end else begin
            if (idle_cnt != 8'hff) idle_cnt <= idle_cnt + 8'd1;
            if (drain_done) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] wait_cnt;
  logic          waiting;

  always_comb begin
    waiting = 1'b0;
    unique case (state)
      GNT_MEMIO: waiting = host_req_i;
      GNT_HOST:  waiting = memio_req_i;
      DRAIN:     waiting = last_memio ? host_req_i : memio_req_i;
      default:   waiting = 1'b0;
    endcase
  end

  // Saturates at TIMEOUT so the pulse fires once per wait episode.
  always_ff @(posedge clk_i) begin
    if (rst_i || !waiting || drain_done) begin
      wait_cnt       <= '0;
      timeout_intr_o <= 1'b0;
    end else if (wait_cnt != TO_LIM) begin
      wait_cnt       <= wait_cnt + 1'b1;
      timeout_intr_o <= (wait_cnt == TO_LAST);
    end else begin
      timeout_intr_o <= 1'b0;
    end
  end
`else
  assign timeout_intr_o = 1'b0;
`endif

endmodule
